// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard entry type, bubble constant and select-width helper
package pipe_pkg;
  localparam int RAW_DEF = 5;
  localparam int RAW_MAX = 8;
  typedef struct packed {
    logic               valid;
    logic [RAW_MAX-1:0] rd;
    logic               regw;
    logic               load;
  } pipe_entry_t;
  localparam pipe_entry_t BUBBLE = '0;
  function automatic int fw_width(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-side request and hazard/forwarding response bundle
interface pipe_hazard_ctrl_if import pipe_pkg::*; #(
  parameter int STAGES = 3,
  parameter int RAW    = RAW_DEF,
  parameter int CNT_W  = 16
) ();
  localparam int FW = fw_width(STAGES);
  logic              id_valid;
  logic [RAW-1:0]    id_rs1;
  logic [RAW-1:0]    id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RAW-1:0]    id_rd;
  logic              id_regw;
  logic              id_load;
  logic              flush;
  logic              stall;
  logic              issue;
  logic [FW-1:0]     fwd_sel_a;
  logic [FW-1:0]     fwd_sel_b;
  logic [STAGES-1:0] stage_valid;
  logic [RAW-1:0]    wb_rd;
  logic              wb_regw;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regw, id_load, flush,
    input  stall, issue, fwd_sel_a, fwd_sel_b, stage_valid, wb_rd, wb_regw, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regw, id_load, flush,
    output stall, issue, fwd_sel_a, fwd_sel_b, stage_valid, wb_rd, wb_regw, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_sb_slot.sv
// pipe_sb_slot: one scoreboard entry register with its two source-match comparators
module pipe_sb_slot import pipe_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  pipe_entry_t        i_d,
  input  logic [RAW_MAX-1:0] i_rs1,
  input  logic [RAW_MAX-1:0] i_rs2,
  input  logic               i_use_rs1,
  input  logic               i_use_rs2,
  output pipe_entry_t        o_q,
  output logic               o_m1,
  output logic               o_m2
);
  pipe_entry_t r_q;
  // entry advances every cycle; reset empties it to a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= BUBBLE;
    else     r_q <= i_d;
  assign o_q  = r_q;
  assign o_m1 = r_q.valid && r_q.regw && i_use_rs1 && (i_rs1 != '0) && (r_q.rd == i_rs1);
  assign o_m2 = r_q.valid && r_q.regw && i_use_rs2 && (i_rs2 != '0) && (r_q.rd == i_rs2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based load-use stall, operand forwarding and event counters
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int STAGES     = 3,
  parameter int RAW        = RAW_DEF,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int FW = fw_width(STAGES);
  pipe_entry_t        w_q [STAGES];
  pipe_entry_t        w_d [STAGES];
  logic [STAGES-1:0]  w_m1, w_m2, w_ld, w_sv;
  logic [RAW_MAX-1:0] w_rs1, w_rs2;
  logic               w_haz, w_stall, w_issue;
  logic [FW-1:0]      w_sel_a, w_sel_b;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  assign w_rs1 = RAW_MAX'(bus.id_rs1);
  assign w_rs2 = RAW_MAX'(bus.id_rs2);
  assign w_d[0] = w_issue ? pipe_entry_t'{valid: 1'b1, rd: RAW_MAX'(bus.id_rd), regw: bus.id_regw, load: bus.id_load} : BUBBLE;
  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_slot
    if (i > 0) begin : g_chain
      assign w_d[i] = w_q[i-1];
    end
    if (i < LOAD_READY) begin : g_early
      assign w_ld[i] = w_q[i].load;
    end else begin : g_late
      assign w_ld[i] = 1'b0;
    end
    assign w_sv[i] = w_q[i].valid;
    pipe_sb_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_d       (w_d[i]),
      .i_rs1     (w_rs1),
      .i_rs2     (w_rs2),
      .i_use_rs1 (bus.id_use_rs1),
      .i_use_rs2 (bus.id_use_rs2),
      .o_q       (w_q[i]),
      .o_m1      (w_m1[i]),
      .o_m2      (w_m2[i])
    );
  end
  // youngest matching stage wins, so scan oldest to youngest and let later hits override
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_sel_a = w_m1[k] ? FW'(k + 1) : w_sel_a;
      w_sel_b = w_m2[k] ? FW'(k + 1) : w_sel_b;
    end
  end
  assign w_haz   = |((w_m1 | w_m2) & w_ld);
  assign w_stall = bus.id_valid && !bus.flush && w_haz;
  assign w_issue = bus.id_valid && !bus.flush && !w_haz;
  // saturating stall/flush event counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall && !(&r_stall_cnt));
      r_flush_cnt <= r_flush_cnt + CNT_W'(bus.flush && bus.id_valid && !(&r_flush_cnt));
    end
  assign bus.stall       = w_stall;
  assign bus.issue       = w_issue;
  assign bus.fwd_sel_a   = w_sel_a;
  assign bus.fwd_sel_b   = w_sel_b;
  assign bus.stage_valid = w_sv;
  assign bus.wb_rd       = w_q[STAGES-1].rd[RAW-1:0];
  assign bus.wb_regw     = w_q[STAGES-1].valid && w_q[STAGES-1].regw;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for a 3-stage and a 5-stage/4-bit-counter instance
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.STAGES(3), .RAW(5), .CNT_W(16)) a_if ();
  pipe_hazard_ctrl_if #(.STAGES(5), .RAW(5), .CNT_W(4))  b_if ();
  pipe_hazard_ctrl #(.STAGES(3), .RAW(5), .LOAD_READY(2), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  pipe_hazard_ctrl #(.STAGES(5), .RAW(5), .LOAD_READY(2), .CNT_W(4))  u_b (.clk(clk), .rst(rst), .bus(b_if));
  typedef struct {
    logic       stall;
    logic       issue;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;
  typedef struct {
    int         due;
    logic [4:0] rd;
  } wb_t;
  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic drive_a(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                         input logic [4:0] rd, input logic rw, ld, fl);
    a_if.id_valid = v; a_if.id_rs1 = rs1; a_if.id_rs2 = rs2; a_if.id_use_rs1 = u1; a_if.id_use_rs2 = u2;
    a_if.id_rd = rd; a_if.id_regw = rw; a_if.id_load = ld; a_if.flush = fl;
  endtask
  task automatic drive_b(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                         input logic [4:0] rd, input logic rw, ld, fl);
    b_if.id_valid = v; b_if.id_rs1 = rs1; b_if.id_rs2 = rs2; b_if.id_use_rs1 = u1; b_if.id_use_rs2 = u2;
    b_if.id_rd = rd; b_if.id_regw = rw; b_if.id_load = ld; b_if.flush = fl;
  endtask
  task automatic step(input string tag, input logic e_stall, e_issue, input logic [1:0] e_fa, e_fb);
    exp_t e;
    exp_q.push_back('{e_stall, e_issue, e_fa, e_fb});
    if (e_issue && a_if.id_regw) wb_q.push_back('{cyc + 3, a_if.id_rd});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".stall"}, a_if.stall, e.stall);
    chk({tag, ".issue"}, a_if.issue, e.issue);
    chk({tag, ".fwd_a"}, a_if.fwd_sel_a, e.fa);
    chk({tag, ".fwd_b"}, a_if.fwd_sel_b, e.fb);
    @(posedge clk);
    #1;
    cyc++;
    if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
      chk({tag, ".wb_regw"}, a_if.wb_regw, 1);
      chk({tag, ".wb_rd"}, a_if.wb_rd, wb_q[0].rd);
      void'(wb_q.pop_front());
    end else chk({tag, ".wb_idle"}, a_if.wb_regw, 0);
  endtask
  initial begin
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst.sv", a_if.stage_valid, 0);
    chk("rst.wb", a_if.wb_regw, 0);
    chk("rst.scnt", a_if.stall_cnt, 0);
    chk("rst.fcnt", a_if.flush_cnt, 0);
    chk("rst.stall", a_if.stall, 0);
    chk("rst.issue", a_if.issue, 0);
    rst = 1'b0;
    drive_a(1, 0, 0, 0, 0, 3, 1, 0, 0); step("alu1", 0, 1, 0, 0);
    drive_a(1, 3, 0, 1, 0, 4, 1, 0, 0); step("b2b", 0, 1, 1, 0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step("gap", 0, 0, 0, 0);
    drive_a(1, 4, 3, 1, 1, 6, 1, 0, 0); step("gapfwd", 0, 1, 2, 3);
    drive_a(1, 0, 0, 0, 0, 5, 1, 1, 0); step("load", 0, 1, 0, 0);
    drive_a(1, 5, 0, 1, 0, 7, 1, 0, 0); step("lu1", 1, 0, 1, 0);
    step("lu2", 1, 0, 2, 0);
    step("lu3", 0, 1, 3, 0);
    chk("lu.scnt", a_if.stall_cnt, 2);
    drive_a(1, 0, 0, 0, 0, 0, 1, 0, 0); step("w0", 0, 1, 0, 0);
    drive_a(1, 0, 0, 1, 1, 8, 0, 0, 0); step("r0", 0, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 9, 1, 1, 0); step("load2", 0, 1, 0, 0);
    drive_a(1, 9, 0, 1, 0, 10, 1, 0, 1); step("flush", 0, 0, 1, 0);
    chk("fl.fcnt", a_if.flush_cnt, 1);
    chk("fl.scnt", a_if.stall_cnt, 2);
    chk("fl.sv0", a_if.stage_valid[0], 0);
    drive_a(1, 9, 0, 1, 0, 10, 1, 0, 0); step("fl_lu", 1, 0, 2, 0);
    step("fl_go", 0, 1, 3, 0);
    chk("fl_go.scnt", a_if.stall_cnt, 3);
    drive_a(1, 0, 0, 0, 0, 11, 1, 0, 0); step("m1", 0, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 12, 1, 0, 0); step("m2", 0, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 13, 1, 0, 0); step("m3", 0, 1, 0, 0);
    chk("m.sv", a_if.stage_valid, 3'b111);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mrst.sv", a_if.stage_valid, 0);
    chk("mrst.wb", a_if.wb_regw, 0);
    chk("mrst.scnt", a_if.stall_cnt, 0);
    chk("mrst.fcnt", a_if.flush_cnt, 0);
    chk("mrst.issue", a_if.issue, 0);
    chk("mrst.fwd", a_if.fwd_sel_a, 0);
    wb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_b(1, 0, 0, 0, 0, 8, 1, 0, 0);
    @(posedge clk);
    #1;
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    drive_b(1, 8, 0, 1, 0, 9, 1, 0, 0);
    #1;
    chk("s5.fwd_a", b_if.fwd_sel_a, 5);
    chk("s5.fwd_b", b_if.fwd_sel_b, 0);
    chk("s5.stall", b_if.stall, 0);
    chk("s5.issue", b_if.issue, 1);
    chk("s5.sv", b_if.stage_valid, 5'b10000);
    chk("s5.wb_regw", b_if.wb_regw, 1);
    chk("s5.wb_rd", b_if.wb_rd, 8);
    @(posedge clk);
    #1;
    drive_b(1, 0, 0, 0, 0, 2, 1, 1, 0);
    @(posedge clk);
    #1;
    drive_b(1, 2, 0, 1, 0, 2, 1, 1, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("sat.mid", b_if.stall_cnt, 6);
    repeat (30) @(posedge clk);
    #1;
    chk("sat.hold", b_if.stall_cnt, 15);
    chk("sat.fcnt", b_if.flush_cnt, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
